// File: rtl/calculation_sub.sv
// -----------------------------------------------------------------------------
// calculation_sub
//
// Multi-cycle unsigned subtractor for the Euclidean-distance datapath. It
// produces d = a - b, the coordinate difference that feeds the squaring stage.
// The borrow ripples through CHUNK-bit slices, one slice per clock. A
// registered borrow carries between slices. A start/done handshake wraps each
// operation.
//
// Optional feature (compile-time macro CALC_SUB_ABS_EN):
//   When defined, an extra ABS cycle replaces a negative result with its
//   magnitude |a - b|. bout still reports a < b.
//   When undefined, d is always the raw modulo-2^WIDTH difference.
//
// Parameters:
//   WIDTH  operand/result width. It must be an integer multiple of CHUNK.
//   CHUNK  bits subtracted per clock. NCHUNK = WIDTH/CHUNK slices.
//
// Ports:
//   sub_clk  in   clock; every state update happens on its rising edge
//   sub_rst  in   asynchronous, active-high reset
//   start    in   operation request; sampled only while idle
//   a        in   minuend, latched when start is accepted
//   b        in   subtrahend, latched when start is accepted
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse; d and bout are valid
//   d        out  difference (or magnitude with CALC_SUB_ABS_EN)
//   bout     out  final borrow, i.e. (a < b) unsigned
// -----------------------------------------------------------------------------
module calculation_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             sub_clk,
  input  logic             sub_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

`ifdef CALC_SUB_ABS_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ABS,
    S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;
`endif

  // One borrow-chain slice: x - y - bin computed at CHUNK+1 bits. The top bit
  // is the borrow out, because a negative result wraps into bit CHUNK.
  function automatic logic [CHUNK:0] sub_slice(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             bin);
    return {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
  endfunction

  // Two's-complement negate. Any overflow past WIDTH bits is discarded.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   slice;

  // The current slice of the latched operands, selected by the slice counter.
  always_comb begin
    a_sl  = a_q[int'(k_q)*CHUNK +: CHUNK];
    b_sl  = b_q[int'(k_q)*CHUNK +: CHUNK];
    slice = sub_slice(a_sl, b_sl, br_q);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    br_d    = br_q;
    d_d     = d_q;
    bout_d  = bout_q;
    a_d     = a_q;
    b_d     = b_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          k_d     = '0;
          br_d    = 1'b0;
          d_d     = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        d_d[int'(k_q)*CHUNK +: CHUNK] = slice[CHUNK-1:0];
        br_d                          = slice[CHUNK];
        if (k_q == K_LAST) begin
          k_d    = '0;
          bout_d = slice[CHUNK];
`ifdef CALC_SUB_ABS_EN
          state_d = slice[CHUNK] ? S_ABS : S_DONE;
`else
          state_d = S_DONE;
`endif
        end else begin
          k_d = k_q + KW'(1);
        end
      end

`ifdef CALC_SUB_ABS_EN
      S_ABS: begin
        // A borrow out means the raw difference is negative. Negating it
        // turns it into the magnitude.
        d_d     = negate(d_q);
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and visible results. These are reset so that a reset during
  // an operation clears busy, done, d and bout at once.
  always_ff @(posedge sub_clk or posedge sub_rst) begin
    if (sub_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      br_q    <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      br_q    <= br_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  // Operand copies are always reloaded before they are used, so they need no
  // reset.
  always_ff @(posedge sub_clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_calculation_sub.sv
// -----------------------------------------------------------------------------
// tb_calculation_sub
//
// Directed testbench for calculation_sub. It uses hand-computed expected
// values and works in both build configurations (CALC_SUB_ABS_EN defined or
// undefined).
// -----------------------------------------------------------------------------
module tb_calculation_sub;

  logic        sub_clk;
  logic        sub_rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        bout;

  int checks;
  int errors;

  calculation_sub #(.WIDTH(32), .CHUNK(8)) dut (
    .sub_clk (sub_clk),
    .sub_rst (sub_rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .d       (d),
    .bout    (bout)
  );

  initial sub_clk = 1'b0;
  always #5 sub_clk = ~sub_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full operation. Operands are scrambled after the accepting edge.
  // With hammer set, start is held high on every busy cycle.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ed, input logic eb, input int elat,
                        input logic hammer);
    int   n;
    int   busy_cnt;
    logic got;
    @(negedge sub_clk);
    a = av; b = bv; start = 1'b1;
    @(posedge sub_clk);              // E0: start sampled here
    n = 1; busy_cnt = 0; got = 1'b0;
    while (!got && n <= 20) begin
      @(negedge sub_clk);
      start = hammer;
      a = ~av ^ 32'h5A5A_0F0F;
      b = bv + 32'd12345;
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
      else n++;
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_lat"},  32'(n), 32'(elat));
      check({tag, "_busy"}, 32'(busy_cnt), 32'(elat));
      check({tag, "_d"},    d, ed);
      check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    end
    start = 1'b0;
    @(negedge sub_clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"},       {31'd0, busy}, 32'd0);
    @(negedge sub_clk);
    check({tag, "_no_redo"}, {31'd0, done}, 32'd0);
    check({tag, "_d_hold"},  d, ed);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    sub_rst = 1'b1;
    start   = 1'b0;
    a       = 32'd0;
    b       = 32'd0;
    repeat (2) @(negedge sub_clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_d",    d,             32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    sub_rst = 1'b0;

    run_op("pos",   32'd10,        32'd3,          32'h0000_0007, 1'b0, 5, 1'b0);
`ifdef CALC_SUB_ABS_EN
    run_op("neg",   32'd3,         32'd10,         32'h0000_0007, 1'b1, 6, 1'b0);
    run_op("zmax",  32'h0000_0000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 6, 1'b0);
`else
    run_op("neg",   32'd3,         32'd10,         32'hFFFF_FFF9, 1'b1, 5, 1'b0);
    run_op("zmax",  32'h0000_0000, 32'hFFFF_FFFF,  32'h0000_0001, 1'b1, 5, 1'b0);
`endif
    run_op("xslc",  32'h0100_0000, 32'h0000_0001,  32'h00FF_FFFF, 1'b0, 5, 1'b0);
    run_op("eq",    32'hDEAD_BEEF, 32'hDEAD_BEEF,  32'h0000_0000, 1'b0, 5, 1'b0);
    run_op("hammr", 32'h8000_0000, 32'h7FFF_FFFF,  32'h0000_0001, 1'b0, 5, 1'b1);

    // Reset during RUN slice 2, i.e. the cycle between E2 and E3.
    @(negedge sub_clk);
    a = 32'h1234_5678; b = 32'h0000_0001; start = 1'b1;
    @(posedge sub_clk);              // E0
    #1 start = 1'b0;
    @(posedge sub_clk);              // E1: slice 0
    @(posedge sub_clk);              // E2: slice 1
    #2 sub_rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_d",    d,             32'd0);
    check("arst_bout", {31'd0, bout}, 32'd0);
    @(negedge sub_clk);
    sub_rst = 1'b0;
    run_op("post_rst", 32'd100, 32'd1, 32'd99, 1'b0, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
